// File: rtl/top.sv
// top: SPI-programmable PWM generator with prescaled 16-bit up/down counter.
// SPI shift logic runs on sclk; writes commit in the clk domain after cs_n rises.
module top (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic miso,
   output logic mosi,
   output logic pwm_out
);
   logic        spi_rst;
   logic [4:0]  bit_q;
   logic [7:0]  sh_q;
   logic [6:0]  cmd_q;
   logic [7:0]  data_q;
   logic        full_q;
   logic [7:0]  tx_q;
   logic        mosi_q;
   logic [7:0]  rd_data;
   logic [2:0]  cs_s_q;
   logic [15:0] period_q, cmp1_q, cmp2_q, cnt_q, cnt_d;
   logic [7:0]  presc_q, psc_q;
   logic        cen_q, crst_q, up_q, pwm_en_q, pwm_q, pwm_d, tick;
   logic [1:0]  func_q;

   assign spi_rst = cs_n | ~rst_n;
   assign mosi    = mosi_q;
   assign pwm_out = pwm_q;

   always_ff @(posedge sclk or posedge spi_rst)
      if (spi_rst) begin
         bit_q <= '0;
         sh_q  <= '0;
      end else begin
         if (bit_q != 5'd16) bit_q <= bit_q + 5'd1;
         sh_q <= {sh_q[6:0], miso};
      end

   // Frame capture survives cs_n so the clk domain can commit it afterwards.
   always_ff @(posedge sclk or negedge rst_n)
      if (!rst_n) begin
         cmd_q  <= '0;
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         if (bit_q == 5'd0) full_q <= 1'b0;
         if (bit_q == 5'd7) cmd_q <= {sh_q[6], sh_q[4:0], miso};
         if (bit_q == 5'd15) begin
            data_q <= {sh_q[6:0], miso};
            full_q <= 1'b1;
         end
      end

   always_ff @(negedge sclk or posedge spi_rst)
      if (spi_rst) begin
         tx_q   <= '0;
         mosi_q <= 1'b0;
      end else if (bit_q == 5'd8 && !cmd_q[6]) begin
         mosi_q <= rd_data[7];
         tx_q   <= {rd_data[6:0], 1'b0};
      end else if (bit_q > 5'd8 && bit_q < 5'd16 && !cmd_q[6]) begin
         mosi_q <= tx_q[7];
         tx_q   <= {tx_q[6:0], 1'b0};
      end else begin
         mosi_q <= 1'b0;
      end

   always_comb begin
      rd_data = 8'h00;
      case (cmd_q[5:0])
         6'h00: rd_data = period_q[7:0];
         6'h01: rd_data = period_q[15:8];
         6'h02: rd_data = {7'd0, cen_q};
         6'h03: rd_data = cmp1_q[7:0];
         6'h04: rd_data = cmp1_q[15:8];
         6'h05: rd_data = cmp2_q[7:0];
         6'h06: rd_data = cmp2_q[15:8];
         6'h07: rd_data = {7'd0, crst_q};
         6'h08: rd_data = cnt_q[7:0];
         6'h09: rd_data = cnt_q[15:8];
         6'h0A: rd_data = presc_q;
         6'h0B: rd_data = {7'd0, up_q};
         6'h0C: rd_data = {7'd0, pwm_en_q};
         6'h0D: rd_data = {6'd0, func_q};
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cs_s_q   <= 3'b111;
         period_q <= '0;
         cmp1_q   <= '0;
         cmp2_q   <= '0;
         presc_q  <= '0;
         cen_q    <= 1'b0;
         crst_q   <= 1'b0;
         up_q     <= 1'b1;
         pwm_en_q <= 1'b0;
         func_q   <= '0;
      end else begin
         cs_s_q <= {cs_s_q[1:0], cs_n};
         if (cs_s_q[1] && !cs_s_q[2] && full_q && cmd_q[6])
            case (cmd_q[5:0])
               6'h00: period_q[7:0]  <= data_q;
               6'h01: period_q[15:8] <= data_q;
               6'h02: cen_q          <= data_q[0];
               6'h03: cmp1_q[7:0]    <= data_q;
               6'h04: cmp1_q[15:8]   <= data_q;
               6'h05: cmp2_q[7:0]    <= data_q;
               6'h06: cmp2_q[15:8]   <= data_q;
               6'h07: crst_q         <= data_q[0];
               6'h0A: presc_q        <= data_q;
               6'h0B: up_q           <= data_q[0];
               6'h0C: pwm_en_q       <= data_q[0];
               6'h0D: func_q         <= data_q[1:0];
               default: ;
            endcase
      end

   always_comb begin
      tick  = cen_q && psc_q == presc_q;
      cnt_d = up_q ? (cnt_q >= period_q ? 16'd0 : cnt_q + 16'd1)
                   : ((cnt_q == 16'd0 || cnt_q > period_q) ? period_q : cnt_q - 16'd1);
      pwm_d = pwm_en_q & (func_q == 2'd0 ? (cmp1_q != 16'd0 && cnt_q <= cmp1_q) :
                          func_q == 2'd1 ? cnt_q >= cmp1_q :
                          func_q == 2'd2 ? (cmp1_q <= cnt_q && cnt_q < cmp2_q) : 1'b0);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         psc_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
         if (crst_q) begin
            cnt_q <= '0;
            psc_q <= '0;
         end else if (cen_q) begin
            psc_q <= tick ? 8'd0 : psc_q + 8'd1;
            if (tick) cnt_q <= cnt_d;
         end
      end
endmodule

// File: tb/tb_top.sv
// tb_top: directed SPI programming of the PWM generator with duty-cycle checks.
module tb_top;
   logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, miso = 1'b0;
   logic mosi, pwm_out;
   int errors = 0, checks = 0;

   top dut (.clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .miso(miso),
            .mosi(mosi), .pwm_out(pwm_out));

   always #5 clk = ~clk;

   task automatic spi(input logic [7:0] c, input logic [7:0] d, output logic [7:0] r);
      r = 8'h00;
      cs_n = 1'b0;
      #20;
      for (int i = 0; i < 16; i++) begin
         miso = (i < 8) ? c[7-i] : d[15-i];
         #20;
         if (i >= 8) r = {r[6:0], mosi};
         sclk = 1'b1;
         #20;
         sclk = 1'b0;
      end
      #20;
      cs_n = 1'b1;
      miso = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      logic [7:0] r;
      spi({2'b11, a}, d, r);
   endtask

   task automatic rd(input logic [5:0] a, output logic [7:0] r);
      spi({2'b01, a}, 8'h00, r);
   endtask

   task automatic wr16(input logic [5:0] a, input logic [15:0] v);
      wr(a, v[7:0]);
      wr(a + 6'd1, v[15:8]);
   endtask

   task automatic count_high(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         c += int'(pwm_out);
      end
   endtask

   task automatic chk_rd(input string name, input logic [5:0] a, input logic [7:0] exp);
      logic [7:0] r;
      rd(a, r);
      checks++;
      if (r !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, r, exp);
      end
   endtask

   task automatic chk_duty(input string name, input int n, input int lo, input int hi);
      int c;
      count_high(n, c);
      checks++;
      if (c < lo || c > hi) begin
         errors++;
         $display("FAIL %s: high cycles %0d expected %0d..%0d", name, c, lo, hi);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (pwm_out !== 1'b0 || mosi !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: pwm=%b mosi=%b expected 0 0", pwm_out, mosi);
      end
      chk_rd("reset_updown", 6'h0B, 8'h01);
      chk_rd("reset_period", 6'h00, 8'h00);
      chk_rd("reset_counter", 6'h08, 8'h00);
      checks++;
      if (mosi !== 1'b0) begin
         errors++;
         $display("FAIL idle_mosi: got %b expected 0", mosi);
      end
   endtask

   task automatic test_regs;
      wr16(6'h00, 16'd7);
      chk_rd("period_lo", 6'h00, 8'h07);
      chk_rd("period_hi", 6'h01, 8'h00);
      wr(6'h0A, 8'hAB);
      chk_rd("prescale", 6'h0A, 8'hAB);
      wr(6'h0D, 8'hFF);
      chk_rd("functions_mask", 6'h0D, 8'h03);
      wr(6'h20, 8'h5A);
      chk_rd("unmapped", 6'h20, 8'h00);
      wr(6'h08, 8'h55);
      chk_rd("counter_ro", 6'h08, 8'h00);
      wr(6'h0A, 8'h00);
      wr(6'h0D, 8'h00);
   endtask

   task automatic test_left;
      logic [7:0] r;
      wr16(6'h03, 16'd3);
      wr(6'h02, 8'h01);
      wr(6'h0C, 8'h01);
      wr(6'h07, 8'h01);
      repeat (5) @(posedge clk);
      chk_rd("counter_reset_hold", 6'h08, 8'h00);
      wr(6'h07, 8'h00);
      chk_duty("left_align", 40, 19, 21);
      rd(6'h08, r);
      checks++;
      if (r > 8'd7) begin
         errors++;
         $display("FAIL counter_read: got %0d expected 0..7", r);
      end
   endtask

   task automatic test_range;
      wr16(6'h03, 16'd2);
      wr16(6'h05, 16'd6);
      wr(6'h0D, 8'h02);
      chk_duty("range", 40, 19, 21);
   endtask

   task automatic test_right;
      wr16(6'h03, 16'd5);
      wr(6'h0D, 8'h01);
      chk_duty("right_align", 40, 14, 16);
   endtask

   task automatic test_range_empty;
      wr(6'h02, 8'h00);
      wr(6'h0D, 8'h02);
      wr16(6'h03, 16'd5);
      wr16(6'h05, 16'd5);
      wr(6'h02, 8'h01);
      chk_duty("range_empty", 16, 0, 1);
   endtask

   task automatic test_left_zero;
      wr(6'h02, 8'h00);
      wr16(6'h03, 16'd0);
      wr(6'h0D, 8'h00);
      wr(6'h02, 8'h01);
      chk_duty("left_zero", 24, 0, 1);
   endtask

   task automatic test_down;
      wr16(6'h03, 16'd3);
      wr(6'h0B, 8'h00);
      chk_duty("down_left", 40, 19, 21);
      wr(6'h0B, 8'h01);
   endtask

   task automatic test_prescale;
      wr(6'h0A, 8'h01);
      chk_duty("prescale_1", 48, 23, 25);
      wr(6'h0A, 8'h00);
   endtask

   task automatic test_pwm_disable;
      wr(6'h0C, 8'h00);
      for (int f = 0; f < 4; f++) begin
         wr(6'h0D, 8'(f));
         chk_duty($sformatf("pwm_disabled_f%0d", f), 16, 0, 0);
      end
   endtask

   task automatic test_mid_reset;
      logic [7:0] c, d;
      c = 8'hC0;
      d = 8'h55;
      cs_n = 1'b0;
      #20;
      for (int i = 0; i < 16; i++) begin
         miso = (i < 8) ? c[7-i] : d[15-i];
         #20;
         sclk = 1'b1;
         #20;
         sclk = 1'b0;
      end
      #20;
      rst_n = 1'b0;
      #30;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      cs_n = 1'b1;
      miso = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk_rd("mid_reset_no_write", 6'h00, 8'h00);
      chk_rd("mid_reset_updown", 6'h0B, 8'h01);
   endtask

   initial begin
      test_reset;
      test_regs;
      test_left;
      test_range;
      test_right;
      test_range_empty;
      test_left_zero;
      test_down;
      test_prescale;
      test_pwm_disable;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/top.md
Name: top

Overview:
- SPI-programmable PWM generator: an SPI slave front end, a register file, a prescaled 16-bit up/down counter, and a PWM comparator.
- An external SPI master configures period, compares, prescale, direction and alignment mode, and can read back the live counter.
- `pwm_out` is the single PWM output.

Parameters:
- None. All widths are fixed: counter/period/compares 16 bits, SPI bytes 8 bits, address 6 bits.

Ports:
- clk  input  1  system clock; all registers, counter and PWM logic.
- rst_n  input  1  reset; asynchronous, active-low.
- sclk  input  1  SPI serial clock, idle low (mode 0).
- cs_n  input  1  SPI chip select, active-low.
- miso  input  1  serial data from master into block (port naming is inverted by convention).
- mosi  output  1  serial data from block to master.
- pwm_out  output  1  PWM output.

Behaviour:
- Reset: all registers 0 except UPNOTDOWN=1. Counter 0, prescaler 0, pwm_out=0, mosi=0.
- SPI framing:
  - Mode 0. Input sampled on sclk rising edge; mosi updated on sclk falling edge. Both MSB first.
  - The SPI shift logic is clocked directly by sclk, because sclk may run as fast as clk.
  - cs_n high resets the bit counter and holds mosi at 0.
  - Byte 0 is the command: bit7 = 1 write / 0 read; bit6 reserved (master sends 1, ignored); bits5:0 = address.
  - Byte 1 is data. On write it is shifted in. On read, the addressed register value is loaded at the 8th sclk falling edge, so bit7 is valid before the 9th rising edge, then shifted out.
  - Extra bytes beyond two are ignored.
- Write commit: on cs_n rising edge, resynchronised into clk with a 2-FF synchroniser. If a full 16-bit write frame was received, data is written to the addressed register. The register updates ≤4 clk cycles after cs_n rises.
- Register map (16-bit registers: low byte at base, high byte at base+1):
  - 0x00/0x01 PERIOD
  - 0x02 COUNTER_EN[0]
  - 0x03/0x04 COMPARE1
  - 0x05/0x06 COMPARE2
  - 0x07 COUNTER_RESET[0]
  - 0x08/0x09 COUNTER_VAL, read-only
  - 0x0A PRESCALE[7:0]
  - 0x0B UPNOTDOWN[0]
  - 0x0C PWM_EN[0]
  - 0x0D FUNCTIONS[1:0]
  - Unused bits read 0. Unmapped addresses read 0; writes to them and to 0x08/0x09 are ignored.
- Prescaler: one counter tick every (PRESCALE+1) clk cycles while COUNTER_EN=1.
- Counter:
  - Up mode (UPNOTDOWN=1): 0,1,…,PERIOD, then 0. If the counter is ≥PERIOD at a tick (e.g. PERIOD lowered), it goes to 0.
  - Down mode: PERIOD,…,0, then PERIOD. If it is above PERIOD, it loads PERIOD.
  - One full cycle is PERIOD+1 ticks.
  - COUNTER_EN=0 freezes the counter.
  - COUNTER_RESET=1 holds counter and prescaler at 0 until written 0. It takes priority over enable.
- PWM, registered, 1 clk latency from counter; forced 0 when PWM_EN=0. By FUNCTIONS:
  - 00 align-left: high when COMPARE1≠0 and counter ≤ COMPARE1. COMPARE1=0 gives a constant low.
  - 01 align-right: high when counter ≥ COMPARE1.
  - 10 range: high when COMPARE1 ≤ counter < COMPARE2. COMPARE1 ≥ COMPARE2 gives a constant low.
  - 11: low.
- Reset mid-transaction: abandons the SPI frame and writes nothing.

Test Plan:
- PERIOD=7, PRESCALE=0, COMPARE1=3, COUNTER_EN=1, PWM_EN=1, FUNCTIONS=00; pulse COUNTER_RESET 1→0 -> over 40 clk, pwm_out high 20±1 cycles (4 per period).
- Then read 0x08 -> returns the current counter value in 0..7.
- COMPARE1=2, COMPARE2=6, FUNCTIONS=10 -> 20±1 high cycles over 40 clk.
- COMPARE1=5, FUNCTIONS=01 -> 15±1 high cycles over 40 clk.
- COUNTER_EN=0, FUNCTIONS=10, COMPARE1=COMPARE2=5, COUNTER_EN=1 -> ≤1 high cycle over 16 clk.
- COUNTER_EN=0, COMPARE1=0, FUNCTIONS=00, COUNTER_EN=1 -> ≤1 high cycle over 24 clk. Additionally, PWM_EN=0 -> pwm_out stays 0 in every mode.
